// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the instruction-fetch slice of the pipeline.
//   RESET_PC_DEFAULT : first fetch address after reset unless overridden
//   NOP_WORD         : instruction word held in IF/ID while it is empty
//   fetch_state_e    : RUN (normal fetching) / DROP (waiting to discard a
//                      word whose request was issued before a redirect)
//   word_align()     : clears the two byte-offset bits of an address
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding register for a fetched word that arrived while the
// decode stage was stalled.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push             : store push_ins/push_pc (only issued while empty)
//   pop              : entry consumed by IF/ID
//   flush            : discard the entry (redirect); wins over push/pop
//   push_ins/push_pc : word and its address to store
//   full             : entry holds a word
//   ins/pc           : stored word and its address
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_ins,
    input  logic [31:0] push_pc,
    output logic        full,
    output logic [31:0] ins,
    output logic [31:0] pc
);

    logic        full_q, full_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        full_d = full_q;
        ins_d  = ins_q;
        pc_d   = pc_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (push) begin
            full_d = 1'b1;
            ins_d  = push_ins;
            pc_d   = push_pc;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            ins_q  <= NOP_WORD;
            pc_q   <= 32'h0000_0000;
        end else begin
            full_q <= full_d;
            ins_q  <= ins_d;
            pc_q   <= pc_d;
        end
    end

    assign full = full_q;
    assign ins  = ins_q;
    assign pc   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: issues word reads to instruction memory, fills
// the IF/ID register, absorbs one word in a skid buffer during decode
// stalls and redirects on taken branches resolved in ID.
//   clk, rst_n           : clock, asynchronous active-low reset
//   imem_req/imem_addr   : registered read request and word address
//   imem_ready/imem_rdata: read completion and returned word
//   stall                : hold IF/ID (hazard in decode)
//   branch/b_addr        : taken-branch redirect and target
//   if_id_ins/if_id_pc   : IF/ID instruction and its address
//   if_id_valid          : IF/ID holds a live instruction
// Build option: define BRANCH_DELAY_SLOT_EN to deliver the sequential
// word after an accepted branch as a delay slot instead of discarding it.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] b_addr,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         req_q, req_d;
    logic [31:0]  if_id_ins_q, if_id_ins_d;
    logic [31:0]  if_id_pc_q, if_id_pc_d;
    logic         if_id_valid_q, if_id_valid_d;

    logic         fire;
    logic         br_acc;
    logic [31:0]  b_target;
    logic         buf_push, buf_pop, buf_flush, buf_full, buf_full_next;
    logic [31:0]  buf_ins, buf_pc;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .pop      (buf_pop),
        .flush    (buf_flush),
        .push_ins (imem_rdata),
        .push_pc  (pc_q),
        .full     (buf_full),
        .ins      (buf_ins),
        .pc       (buf_pc)
    );

    assign fire     = req_q & imem_ready;
    // A redirect only counts when the branch is live in ID and not stalled.
    assign br_acc   = branch & if_id_valid_q & ~stall;
    assign b_target = word_align(b_addr);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        if_id_ins_d   = if_id_ins_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        buf_push      = 1'b0;
        buf_pop       = 1'b0;
        buf_flush     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (br_acc) begin
                    buf_flush     = 1'b1;
                    if_id_valid_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
                    // The sequential word already in hand is the delay slot.
                    if (buf_full) begin
                        if_id_ins_d   = buf_ins;
                        if_id_pc_d    = buf_pc;
                        if_id_valid_d = 1'b1;
                    end else if (fire) begin
                        if_id_ins_d   = imem_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                    end
`endif
                    // An unanswered request must keep its address until the
                    // memory answers, so the redirect waits in DROP.
                    if (req_q && !imem_ready) begin
                        state_d  = DROP;
                        target_d = b_target;
                    end else begin
                        pc_d = b_target;
                    end
                end else if (buf_full) begin
                    if (!stall) begin
                        if_id_ins_d   = buf_ins;
                        if_id_pc_d    = buf_pc;
                        if_id_valid_d = 1'b1;
                        buf_pop       = 1'b1;
                    end
                end else if (fire) begin
                    pc_d = pc_q + 32'd4;
                    if (stall) begin
                        buf_push = 1'b1;
                    end else begin
                        if_id_ins_d   = imem_rdata;
                        if_id_pc_d    = pc_q;
                        if_id_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
            end
            DROP: begin
                if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
                if (br_acc) begin
                    target_d = b_target;
                end
                if (fire) begin
                    state_d = RUN;
                    pc_d    = br_acc ? b_target : target_q;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (!br_acc) begin
                        if (stall) begin
                            buf_push = 1'b1;
                        end else begin
                            if_id_ins_d   = imem_rdata;
                            if_id_pc_d    = pc_q;
                            if_id_valid_d = 1'b1;
                        end
                    end
`endif
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Request is dropped only while the skid buffer holds a word.
    assign buf_full_next = buf_push | (buf_full & ~buf_pop & ~buf_flush);
    assign req_d         = ~buf_full_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            target_q      <= RESET_PC;
            req_q         <= 1'b0;
            if_id_ins_q   <= NOP_WORD;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            req_q         <= req_d;
            if_id_ins_q   <= if_id_ins_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_id_ins   = if_id_ins_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Scoreboard bench for fetch_unit: expected handshake addresses and
// expected decode-consumed instructions are queued as each scenario is
// driven; a negedge monitor pops and compares them as the DUT produces
// them. Honours BRANCH_DELAY_SLOT_EN when the design is built with it.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic [31:0] b_addr;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] expAddrQ[$];
    logic [31:0] expPcQ[$];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .b_addr      (b_addr),
        .if_id_ins   (if_id_ins),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address so every word is
    // distinguishable.
    function automatic logic [31:0] insOf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_rdata = insOf(imem_addr);

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and waits for
    // the next rising edge plus a small offset.
    task automatic applyStimulus(input logic s, input logic b,
                                 input logic [31:0] a, input logic r);
        stall      = s;
        branch     = b;
        b_addr     = a;
        imem_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each memory handshake and each instruction taken by decode
    // (valid and not stalled) is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [31:0] expVal;
        if (rst_n) begin
            if (imem_req && imem_ready) begin
                if (expAddrQ.size() == 0) begin
                    checkOutput("hsUnexpected", 32'(expAddrQ.size()), 32'd1);
                end else begin
                    expVal = expAddrQ.pop_front();
                    checkOutput("hsAddr", imem_addr, expVal);
                end
            end
            if (if_id_valid && !stall) begin
                if (expPcQ.size() == 0) begin
                    checkOutput("idUnexpected", 32'(expPcQ.size()), 32'd1);
                end else begin
                    expVal = expPcQ.pop_front();
                    checkOutput("idPc", if_id_pc, expVal);
                    checkOutput("idIns", if_id_ins, insOf(expVal));
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        b_addr     = 32'h0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
        checkOutput("rstValid", {31'b0, if_id_valid}, 32'd0);
        checkOutput("rstIns", if_id_ins, 32'h0);
        checkOutput("rstPc", if_id_pc, 32'h0);
        checkOutput("rstAddr", imem_addr, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch with memory always ready.
        expAddrQ.push_back(32'h0);  expAddrQ.push_back(32'h4);
        expAddrQ.push_back(32'h8);  expAddrQ.push_back(32'hC);
        expPcQ.push_back(32'h0);    expPcQ.push_back(32'h4);
        expPcQ.push_back(32'h8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("firstReq", {31'b0, imem_req}, 32'd1);
        checkOutput("firstAddr", imem_addr, 32'h0);
        checkOutput("firstValid", {31'b0, if_id_valid}, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Three stalled cycles with memory ready: one word skids.
        expAddrQ.push_back(32'h10); expAddrQ.push_back(32'h14);
        expAddrQ.push_back(32'h18);
        expPcQ.push_back(32'hC);    expPcQ.push_back(32'h10);
        expPcQ.push_back(32'h14);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("skidReqLow", {31'b0, imem_req}, 32'd0);
        checkOutput("skidHoldPc", if_id_pc, 32'hC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("skidDrainPc", if_id_pc, 32'h10);
        checkOutput("skidReqBack", {31'b0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Branch with ready in the same cycle; target has stray low bits.
        expAddrQ.push_back(32'h1C); expAddrQ.push_back(32'h40);
        expAddrQ.push_back(32'h44); expAddrQ.push_back(32'h48);
        expPcQ.push_back(32'h18);
`ifdef BRANCH_DELAY_SLOT_EN
        expPcQ.push_back(32'h1C);
`endif
        expPcQ.push_back(32'h40);   expPcQ.push_back(32'h44);
        applyStimulus(1'b0, 1'b1, 32'h43, 1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        checkOutput("brSameValid", {31'b0, if_id_valid}, 32'd1);
`else
        checkOutput("brSameValid", {31'b0, if_id_valid}, 32'd0);
`endif
        checkOutput("brSameAddr", imem_addr, 32'h40);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Branch while a request is outstanding; ready arrives 3 cycles on.
        expAddrQ.push_back(32'h4C); expAddrQ.push_back(32'h40);
        expAddrQ.push_back(32'h44); expAddrQ.push_back(32'h48);
        expPcQ.push_back(32'h48);
`ifdef BRANCH_DELAY_SLOT_EN
        expPcQ.push_back(32'h4C);
`endif
        expPcQ.push_back(32'h40);   expPcQ.push_back(32'h44);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("dropHoldAddr1", imem_addr, 32'h4C);
        checkOutput("dropValid", {31'b0, if_id_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("dropHoldAddr2", imem_addr, 32'h4C);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Branch together with stall: no redirect, nothing moves.
        expAddrQ.push_back(32'h4C); expAddrQ.push_back(32'h50);
        expPcQ.push_back(32'h48);   expPcQ.push_back(32'h4C);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        checkOutput("stallBrPc", if_id_pc, 32'h48);
        checkOutput("stallBrValid", {31'b0, if_id_valid}, 32'd1);
        checkOutput("stallBrAddr", imem_addr, 32'h4C);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        checkOutput("stallBrAddr2", imem_addr, 32'h4C);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Address wrap at the top of the address space.
        expAddrQ.push_back(32'h54);        expAddrQ.push_back(32'hFFFF_FFF8);
        expAddrQ.push_back(32'hFFFF_FFFC); expAddrQ.push_back(32'h0);
        expAddrQ.push_back(32'h4);
        expPcQ.push_back(32'h50);
`ifdef BRANCH_DELAY_SLOT_EN
        expPcQ.push_back(32'h54);
`endif
        expPcQ.push_back(32'hFFFF_FFF8);   expPcQ.push_back(32'hFFFF_FFFC);
        expPcQ.push_back(32'h0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrapAddr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of an outstanding request.
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstReq", {31'b0, imem_req}, 32'd0);
        checkOutput("midRstValid", {31'b0, if_id_valid}, 32'd0);
        checkOutput("midRstPc", if_id_pc, 32'h0);
        checkOutput("midRstAddr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("relReqLow", {31'b0, imem_req}, 32'd0);
        expAddrQ.push_back(32'h0);  expAddrQ.push_back(32'h4);
        expPcQ.push_back(32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("relReq", {31'b0, imem_req}, 32'd1);
        checkOutput("relAddr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

        checkOutput("hsQueueLeft", 32'(expAddrQ.size()), 32'd0);
        checkOutput("idQueueLeft", 32'(expPcQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first instruction address after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, listed first below.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  read address, word aligned.
REQ-007 SHALL have port imem_ready  input  1  imem_rdata valid this cycle; completes the request.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port stall  input  1  hazard hold of IF/ID (load-use or branch operand not yet available).
REQ-010 SHALL have port branch  input  1  taken-branch redirect from the ID-stage branch resolver.
REQ-011 SHALL have port b_addr  input  32  redirect target.
REQ-012 SHALL have ports if_id_ins, if_id_pc  output  32 each  IF/ID instruction and its address.
REQ-013 SHALL have port if_id_valid  output  1  IF/ID holds a live instruction.

Function
REQ-014 SHALL keep imem_addr and imem_req stable from assertion until the cycle imem_ready is high; ready with req low is ignored.
REQ-015 SHALL assert imem_req every cycle except when the skid buffer is full; req and addr are driven from registers (no combinational path from inputs).
REQ-016 SHALL, in state RUN, on imem_ready with stall low and buffer empty, load IF/ID with {imem_rdata, imem_addr}, set if_id_valid, and advance pc by 4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
REQ-017 SHALL, on imem_ready with stall high, capture the word and its address in the one-entry skid buffer, advance pc, and hold IF/ID unchanged.
REQ-018 SHALL, on the first cycle stall is low with the buffer full, load IF/ID from the buffer and empty it; imem_req reasserts that same cycle.
REQ-019 SHALL, with stall low and no word available, clear if_id_valid (bubble).
REQ-020 SHALL act on branch only when if_id_valid=1 and stall=0; branch with stall high is ignored, stall wins.
REQ-021 SHALL, on an accepted branch, set pc to b_addr, empty the skid buffer, and clear if_id_valid next cycle.
REQ-022 SHALL, on an accepted branch, discard a word returned in the same cycle; if a request is outstanding without ready, enter state DROP, keep the old address until ready, discard that word, then return to RUN issuing b_addr.
REQ-023 SHALL accept a new branch while in DROP by replacing the pending target; the last accepted target is used.
REQ-024 SHALL ignore the low two bits of b_addr (forced to 0).

Reset
REQ-025 SHALL, while rst_n=0, drive imem_req=0, if_id_valid=0, if_id_ins=0, if_id_pc=0, pc=RESET_PC, buffer empty, state RUN.
REQ-026 SHALL, on reset assertion mid-request, abandon the request; the first request after release is RESET_PC, one cycle after release.

Configuration
REQ-027 SHALL, with BRANCH_DELAY_SLOT_EN defined, deliver exactly one instruction after an accepted branch (branch pc+4, from buffer, same-cycle ready or DROP word) to IF/ID before the first target instruction.
REQ-028 SHALL, without BRANCH_DELAY_SLOT_EN, discard all post-branch sequential words per REQ-021/022 (no delay slot).

Structure
REQ-029 SHALL take RESET_PC default, the state enum (RUN, DROP) and NOP word 32'h0 from shared package mips_pkg.
REQ-030 SHALL implement the skid buffer as sub-module fetch_skid_buf (one entry, flush input).

Verification
REQ-031 Reset release, imem_ready always 1 -> imem_addr 0,4,8; if_id_pc 0 valid on the second post-release edge.
REQ-032 stall high 3 cycles during ready -> one word buffered, imem_req low, IF/ID held; stall low -> buffered word in IF/ID, next word follows with no gap or duplicate.
REQ-033 branch=1, b_addr=32'h40, ready same cycle -> returned word dropped, if_id_valid=0 next cycle, next imem_addr 32'h40.
REQ-034 branch while request outstanding, ready 3 cycles later -> addr held 3 cycles, word dropped, then 32'h40 issued; with BRANCH_DELAY_SLOT_EN that word appears in IF/ID first.
REQ-035 branch and stall both high -> no redirect, pc and IF/ID unchanged.
REQ-036 pc=32'hFFFF_FFFC fetched -> next imem_addr 32'h0000_0000.
